uart_rx: RTL

UART receiver: the receive-side counterpart of the transmit baud generator/transmitter path. It contains its own 16x-oversampling tick generator, a 2-flop input synchronizer, start-bit validation, mid-bit sampling and a stop-bit check. It delivers each 8N1 frame (LSB first) as a byte with a one-cycle valid strobe. It sits between the external `rx` pin and the user logic.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 receiver with free-running 16x tick,
// 2-flop synchronizer, start validation and stop check.
module uart_rx #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam logic [31:0] TICK_MAX = 32'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_e;

   logic        sync1_q;
   logic        sync2_q;
   logic        rx_s;
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;
   logic        tick;
   state_e      state_q;
   logic [3:0]  smp_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        ferr_q;
   logic        busy_q;

   assign rx_s = sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   // Free-running tick; never re-phased by line activity
   assign tick = (cnt_q == TICK_MAX);

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (tick) cnt_d = 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 32'd0;
      else     cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         smp_q   <= 4'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (tick) begin
            unique case (state_q)
               S_IDLE: begin
                  if (!rx_s) begin
                     state_q <= S_START;
                     smp_q   <= 4'd0;
                     busy_q  <= 1'b1;
                  end
               end
               S_START: begin
                  if (smp_q == 4'd7) begin
                     if (!rx_s) begin
                        state_q <= S_DATA;
                        smp_q   <= 4'd0;
                        bit_q   <= 3'd0;
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     smp_q <= smp_q + 4'd1;
                  end
               end
               S_DATA: begin
                  if (smp_q == 4'd15) begin
                     shift_q <= {rx_s, shift_q[7:1]};
                     smp_q   <= 4'd0;
                     if (bit_q == 3'd7) state_q <= S_STOP;
                     else               bit_q   <= bit_q + 3'd1;
                  end else begin
                     smp_q <= smp_q + 4'd1;
                  end
               end
               S_STOP: begin
                  if (smp_q == 4'd15) begin
                     smp_q <= 4'd0;
                     if (rx_s) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= S_BREAK;
                     end
                  end else begin
                     smp_q <= smp_q + 4'd1;
                  end
               end
               S_BREAK: begin
                  if (rx_s) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_busy   = busy_q;

endmodule
